// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a registered carry,
// adding WIDTH-bit operands LSB first, one bit per clock.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ss;
  logic             cf;
  logic [CW-1:0]    cnt;
  logic             fs;
  logic             fc;
  logic [WIDTH-1:0] snext;

  full_adder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (cf),
    .s  (fs),
    .co (fc)
  );

  // new sum bit enters at the MSB as the S register shifts right
  assign snext = {fs, ss[WIDTH-1:1]};

  // control FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      ss    <= '0;
      cf    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            cf    <= cin;
            ss    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          ss <= snext;
          cf <= fc;
          if (cnt == LAST) begin
            sum   <= snext;
            carry <= fc;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
